program_feeder: RTL and testbench
=================================

// Module: program_feeder
// PURPOSE
//   Program sequencer that drives the 10-bit processor's external data input (Data_in) instead of the switches.
//   Holds a small program image, presents instruction words at T0 and immediate words on Ext requests,
//   and advances in lock-step with the processor's debounced step clock.
//   Sits between the board inputs and the processor top; data_out connects to the processor's Data_in.
// PARAMETERS
//   WIDTH      10     data/instruction word width
//   DEPTH      16     program memory words
//   ADDR_W     4      program counter width, = $clog2(DEPTH)
//   HALT_WORD  10'h3FF  instruction encoding that ends the program (never presented to the processor)
// PORTS
//   CLK        in   1       system clock (50 MHz); all state changes on rising edge
//   RSTb       in   1       synchronous reset, active-low
//   step       in   1       one-CLK pulse per processor step (from debounced clock key); qualifies all handshakes
//   ir_load    in   1       processor IRin: instruction register loads on this step
//   ext_req    in   1       processor Ext: processor reads Data_in on this step
//   done       in   1       processor done: current instruction completes on this step
//   load_en    in   1       program-write strobe (IDLE only)
//   load_addr  in   ADDR_W  program-write address
//   load_data  in   WIDTH   program-write data
//   run        in   1       start pulse (IDLE only)
//   data_out   out  WIDTH   word presented to processor Data_in
//   data_valid out  1       data_out carries a live instruction/immediate
//   pc         out  ADDR_W  address of word currently presented
//   halted     out  1       program ended (HALT_WORD or overrun)
//   overrun    out  1       pc ran past DEPTH-1 without HALT_WORD
// BEHAVIOUR
//   Reset (RSTb=0 at edge): state=IDLE, pc=0, halted=0, overrun=0, data_valid=0; memory contents retained.
//   data_out = data_valid ? mem[pc] : '0 (combinational from registered pc/state; zero added latency).
//   States:
//   IDLE:  load_en writes mem[load_addr]<=load_data on the edge. run -> pc<=0, FETCH. run and load_en in same
//          cycle: write completes, then FETCH. step/ir_load/ext_req/done ignored.
//   FETCH: data_valid=1. If mem[pc]==HALT_WORD -> HALT (data_valid drops next cycle, halted<=1).
//          Else on step&&ir_load: pc<=pc+1, EXEC. step without ir_load: hold.
//   EXEC:  data_valid=1 (immediate = mem[pc]). On step&&ext_req: pc<=pc+1 (word consumed).
//          On step&&done: -> FETCH. step&&ext_req&&done together: consume immediate, then FETCH at pc+1.
//   HALT:  data_valid=0, halted=1; load_en ignored; run -> clear halted/overrun, pc<=0, FETCH (rerun).
//   Increment at pc==DEPTH-1 (any consume): pc wraps to 0, overrun<=1, -> HALT.
//   load_en or run outside their allowed states: ignored, no side effect.
//   Reset mid-operation: immediate return to IDLE per reset values; program image preserved.
//   Processor protocol errors (ext_req in FETCH, ir_load in EXEC) ignored; pc not advanced.
// STRUCTURE
//   feeder_pkg: state enum {IDLE, FETCH, EXEC, HALT}, WIDTH, HALT_WORD constants.
//   Sub-module prog_mem: DEPTH x WIDTH register array, one sync write port, one async read port (no reset).
//   Top: FSM + pc + flag registers; one always_ff, one always_comb next-state block.
// TESTING
//   Load mem[0]=10'h041, mem[1]=10'h005, mem[2]=HALT_WORD, run -> FETCH, data_out=10'h041, pc=0, data_valid=1.
//   step+ir_load -> pc=1, EXEC, data_out=10'h005; step+ext_req+done same cycle -> FETCH pc=2 -> HALT, halted=1, data_out=0.
//   Fill all 16 words with 10'h000, run, step+ir_load then step+done x16 -> pc wraps 0, overrun=1, halted=1.
//   RSTb=0 during EXEC at pc=5 -> next edge IDLE, pc=0, data_valid=0; run again -> data_out equals pre-reset mem[0].
//   load_en pulses in FETCH/EXEC/HALT -> memory unchanged (read back after return to IDLE via reset).
//   step without ir_load in FETCH and ext_req in FETCH -> pc and state unchanged across 4 steps.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared constants and state encoding for the program feeder that drives
// the 10-bit processor's Data_in from a small program image.
package feeder_pkg;

    localparam int WIDTH  = 10;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [WIDTH-1:0] HALT_WORD = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program image storage: register array with one synchronous write port and
// one combinational read port; contents deliberately survive reset.
module prog_mem
    import feeder_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_feeder.sv
// Program sequencer: presents instruction words at fetch and immediates on
// Ext requests, stepping in lock-step with the processor's debounced clock.
module program_feeder
    import feeder_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTb,
    input  logic              step,
    input  logic              ir_load,
    input  logic              ext_req,
    input  logic              done,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              run,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              overrun
);

    feeder_state_t     state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic              halted_n;
    logic              overrun_n;
    logic [WIDTH-1:0]  mem_word;
    logic              last_word;
    logic              mem_we;

    // Writes are only accepted while idle so a running program cannot be disturbed.
    assign mem_we = load_en && (state == IDLE);

    prog_mem u_prog_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (mem_word)
    );

    assign last_word  = (pc == ADDR_W'(DEPTH - 1));
    assign data_valid = (state == FETCH) || (state == EXEC);
    assign data_out   = data_valid ? mem_word : '0;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state   <= IDLE;
            pc      <= '0;
            halted  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            halted  <= halted_n;
            overrun <= overrun_n;
        end
    end

    // Consuming the final word wraps pc and ends the run as an overrun,
    // which takes priority over any concurrent done.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        halted_n  = halted;
        overrun_n = overrun;
        case (state)
            IDLE: begin
                if (run) begin
                    pc_n    = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (mem_word == HALT_WORD) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                end else if (step && ir_load) begin
                    pc_n = pc + ADDR_W'(1);
                    if (last_word) begin
                        state_n   = HALT;
                        halted_n  = 1'b1;
                        overrun_n = 1'b1;
                    end else begin
                        state_n = EXEC;
                    end
                end
            end
            EXEC: begin
                if (step && ext_req) begin
                    pc_n = pc + ADDR_W'(1);
                    if (last_word) begin
                        state_n   = HALT;
                        halted_n  = 1'b1;
                        overrun_n = 1'b1;
                    end else if (done) begin
                        state_n = FETCH;
                    end
                end else if (step && done) begin
                    state_n = FETCH;
                end
            end
            HALT: begin
                if (run) begin
                    pc_n      = '0;
                    halted_n  = 1'b0;
                    overrun_n = 1'b0;
                    state_n   = FETCH;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_feeder.sv
// Directed bench for program_feeder: load/run/halt, overrun wrap, reset
// retention, ignored writes and ignored protocol errors.
module tb_program_feeder;

    logic       CLK = 1'b0;
    logic       RSTb = 1'b0;
    logic       step = 1'b0;
    logic       ir_load = 1'b0;
    logic       ext_req = 1'b0;
    logic       done = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [9:0] load_data = '0;
    logic       run = 1'b0;
    logic [9:0] data_out;
    logic       data_valid;
    logic [3:0] pc;
    logic       halted;
    logic       overrun;

    int testsRun = 0;
    int testsFailed = 0;

    program_feeder dut (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .step       (step),
        .ir_load    (ir_load),
        .ext_req    (ext_req),
        .done       (done),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .run        (run),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pc         (pc),
        .halted     (halted),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Holds the given inputs across exactly one rising edge, then returns to quiet.
    task automatic applyStimulus(input logic s, input logic ir, input logic ex, input logic dn,
                                 input logic le, input logic [3:0] la, input logic [9:0] ld,
                                 input logic rn);
        step = s; ir_load = ir; ext_req = ex; done = dn;
        load_en = le; load_addr = la; load_data = ld; run = rn;
        @(posedge CLK);
        #1;
        step = 0; ir_load = 0; ext_req = 0; done = 0; load_en = 0; run = 0;
    endtask

    task automatic doReset();
        RSTb = 1'b0;
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
    endtask

    initial begin
        @(posedge CLK);
        doReset();
        checkOutput("rst_pc", 16'(pc), 16'h0);
        checkOutput("rst_valid", 16'(data_valid), 16'h0);
        checkOutput("rst_halted", 16'(halted), 16'h0);
        checkOutput("rst_overrun", 16'(overrun), 16'h0);
        checkOutput("rst_data", 16'(data_out), 16'h0);

        applyStimulus(1, 1, 1, 1, 0, 4'd0, 10'h0, 0);
        checkOutput("idle_step_pc", 16'(pc), 16'h0);
        checkOutput("idle_step_valid", 16'(data_valid), 16'h0);

        // Basic program: instruction, immediate, halt.
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 10'h041, 0);
        applyStimulus(0, 0, 0, 0, 1, 4'd1, 10'h005, 0);
        applyStimulus(0, 0, 0, 0, 1, 4'd2, 10'h3FF, 1);
        checkOutput("run_data", 16'(data_out), 16'h041);
        checkOutput("run_pc", 16'(pc), 16'h0);
        checkOutput("run_valid", 16'(data_valid), 16'h1);
        applyStimulus(1, 1, 0, 0, 0, 4'd0, 10'h0, 0);
        checkOutput("exec_pc", 16'(pc), 16'h1);
        checkOutput("exec_data", 16'(data_out), 16'h005);
        applyStimulus(1, 0, 1, 1, 0, 4'd0, 10'h0, 0);
        checkOutput("ext_done_pc", 16'(pc), 16'h2);
        checkOutput("ext_done_halted", 16'(halted), 16'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 10'h0, 0);
        checkOutput("halt_halted", 16'(halted), 16'h1);
        checkOutput("halt_data", 16'(data_out), 16'h0);
        checkOutput("halt_valid", 16'(data_valid), 16'h0);
        checkOutput("halt_overrun", 16'(overrun), 16'h0);

        // Write attempt in HALT, then rerun and probe protocol errors in FETCH.
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 10'h155, 0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 10'h0, 1);
        checkOutput("rerun_halted", 16'(halted), 16'h0);
        checkOutput("rerun_data", 16'(data_out), 16'h041);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 10'h0, 0);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 10'h0, 0);
        applyStimulus(1, 0, 1, 0, 0, 4'd0, 10'h0, 0);
        applyStimulus(1, 0, 1, 0, 1, 4'd1, 10'h2AA, 0);
        checkOutput("fetch_hold_pc", 16'(pc), 16'h0);
        checkOutput("fetch_hold_valid", 16'(data_valid), 16'h1);
        checkOutput("fetch_hold_data", 16'(data_out), 16'h041);
        applyStimulus(1, 1, 0, 0, 0, 4'd0, 10'h0, 0);
        applyStimulus(1, 1, 0, 0, 1, 4'd0, 10'h155, 0);
        checkOutput("exec_irload_pc", 16'(pc), 16'h1);
        checkOutput("exec_irload_valid", 16'(data_valid), 16'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 4'd0, 10'h0, 0);
        end
        checkOutput("exec_pc5", 16'(pc), 16'h5);

        // Reset mid-EXEC keeps the image; stray writes must not have landed.
        doReset();
        checkOutput("midrst_pc", 16'(pc), 16'h0);
        checkOutput("midrst_valid", 16'(data_valid), 16'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 10'h0, 1);
        checkOutput("retain_mem0", 16'(data_out), 16'h041);
        applyStimulus(1, 1, 0, 0, 0, 4'd0, 10'h0, 0);
        checkOutput("retain_mem1", 16'(data_out), 16'h005);
        applyStimulus(1, 0, 1, 0, 0, 4'd0, 10'h0, 0);
        applyStimulus(1, 0, 0, 1, 0, 4'd0, 10'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 10'h0, 0);
        checkOutput("retain_mem2_halt", 16'(halted), 16'h1);

        // Overrun: no HALT_WORD anywhere, pc must wrap and flag.
        doReset();
        for (int a = 0; a < 16; a++) begin
            applyStimulus(0, 0, 0, 0, 1, 4'(a), 10'h000, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 10'h0, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 4'd0, 10'h0, 0);
            if (i < 15) begin
                applyStimulus(1, 0, 0, 1, 0, 4'd0, 10'h0, 0);
            end
            if (i == 14) begin
                checkOutput("ovr_pre_pc", 16'(pc), 16'hF);
                checkOutput("ovr_pre_halted", 16'(halted), 16'h0);
            end
        end
        checkOutput("ovr_pc", 16'(pc), 16'h0);
        checkOutput("ovr_overrun", 16'(overrun), 16'h1);
        checkOutput("ovr_halted", 16'(halted), 16'h1);
        checkOutput("ovr_valid", 16'(data_valid), 16'h0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 10'h0, 1);
        checkOutput("ovr_rerun_overrun", 16'(overrun), 16'h0);
        checkOutput("ovr_rerun_valid", 16'(data_valid), 16'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
